// File: rtl/bist_engine.sv
// bist_engine: built-in self-test engine for one combinational or pipelined CUT.
//
// N_CH LFSR channels generate pattern words. These go to the CUT. The CUT
// responses are compacted into a MISR, and the final signature is compared
// with a golden value.
//
// Ports:
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   start_i      run request, sampled in IDLE or DONE only
//   abort_i      synchronous abort back to IDLE (wins over start_i)
//   seeds_i      per-channel seeds, channel c at [c*LFSR_W +: LFSR_W]
//   golden_i     expected signature
//   pattern_o    registered pattern word to the CUT
//   pat_valid_o  pattern_o is a live test vector this cycle
//   resp_i       CUT response, CUT_LAT cycles after its pattern
//   signature_o  current MISR contents
//   busy_o       run in progress (RUN or FLUSH)
//   done_o       run complete, held until the next start
//   pass_o       signature matched golden on DONE entry
//
// Optional build macro: BIST_PHASE_SHIFT_EN
//   When defined, a phase shifter drives pattern_o:
//   channel c = lfsr[c] ^ rotl1(lfsr[(c+1) mod N_CH]).
//   When undefined, channel c = lfsr[c].
//
// state | meaning
// IDLE  | waiting for start, outputs quiet
// RUN   | presenting PAT_CNT patterns, LFSRs stepping
// FLUSH | draining CUT_LAT pipelined responses into the MISR
// DONE  | signature frozen, done/pass reported until next start

module bist_engine #(
  parameter int unsigned       N_CH      = 6,
  parameter int unsigned       LFSR_W    = 7,
  parameter logic [LFSR_W-1:0] LFSR_TAPS = 7'h60,
  parameter int unsigned       RESP_W    = 17,
  parameter int unsigned       SIG_W     = 10,
  parameter logic [SIG_W-1:0]  MISR_TAPS = 10'h240,
  parameter int unsigned       PAT_CNT   = 256,
  parameter int unsigned       CUT_LAT   = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_i,
  input  logic                   abort_i,
  input  logic [N_CH*LFSR_W-1:0] seeds_i,
  input  logic [SIG_W-1:0]       golden_i,
  output logic [N_CH*LFSR_W-1:0] pattern_o,
  output logic                   pat_valid_o,
  input  logic [RESP_W-1:0]      resp_i,
  output logic [SIG_W-1:0]       signature_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   pass_o
);

  localparam int unsigned DW         = (CUT_LAT > 0) ? CUT_LAT : 1;
  localparam logic [15:0] CNT_LAST   = 16'(PAT_CNT - 1);
  localparam logic [2:0]  FLUSH_LAST = 3'(CUT_LAT - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_e;
  typedef logic [N_CH-1:0][LFSR_W-1:0] lfsr_arr_t;

  state_e            state_q, state_d;
  lfsr_arr_t         lfsr_q, lfsr_d;
  logic [N_CH*LFSR_W-1:0] pattern_q, pattern_d;
  logic              pat_valid_q, pat_valid_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [2:0]        flush_q, flush_d;
  logic [DW-1:0]     dly_q, dly_d;
  logic [SIG_W-1:0]  misr_q, misr_d;
  logic              pass_q, pass_d;
  logic              vdel;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
  endfunction

  function automatic logic [SIG_W-1:0] misr_next(input logic [SIG_W-1:0]  s,
                                                 input logic [RESP_W-1:0] r);
    logic [SIG_W-1:0] f;
    f = '0;
    for (int unsigned j = 0; j < RESP_W; j++) f[j % SIG_W] = f[j % SIG_W] ^ r[j];
    return {s[SIG_W-2:0], ^(s & MISR_TAPS)} ^ f;
  endfunction

  function automatic logic [N_CH*LFSR_W-1:0] shape(input lfsr_arr_t l);
    lfsr_arr_t p;
`ifdef BIST_PHASE_SHIFT_EN
    for (int unsigned c = 0; c < N_CH; c++) begin
      p[c] = l[c] ^ {l[(c+1) % N_CH][LFSR_W-2:0], l[(c+1) % N_CH][LFSR_W-1]};
    end
`else
    p = l;
`endif
    return p;
  endfunction

  // Delayed valid: with zero latency the response belongs to the current pattern.
  assign vdel = (CUT_LAT == 0) ? pat_valid_q : dly_q[DW-1];

  always_comb begin
    logic [LFSR_W-1:0] seed;
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    pattern_d   = pattern_q;
    pat_valid_d = 1'b0;
    cnt_d       = cnt_q;
    flush_d     = flush_q;
    dly_d       = DW'({dly_q, pat_valid_q});
    misr_d      = vdel ? misr_next(misr_q, resp_i) : misr_q;
    pass_d      = pass_q;
    seed        = '0;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          for (int unsigned c = 0; c < N_CH; c++) begin
            seed      = seeds_i[c*LFSR_W +: LFSR_W];
            // an all-zero LFSR would lock up, so substitute all-ones
            lfsr_d[c] = (seed == '0) ? '1 : seed;
          end
          pattern_d   = shape(lfsr_d);
          pat_valid_d = 1'b1;
          misr_d      = '0;
          cnt_d       = '0;
          dly_d       = '0;
          pass_d      = 1'b0;
          state_d     = S_RUN;
        end
      end
      S_RUN: begin
        for (int unsigned c = 0; c < N_CH; c++) lfsr_d[c] = lfsr_next(lfsr_q[c]);
        if (cnt_q == CNT_LAST) begin
          flush_d = '0;
          state_d = (CUT_LAT == 0) ? S_DONE : S_FLUSH;
        end else begin
          cnt_d       = cnt_q + 16'd1;
          pattern_d   = shape(lfsr_d);
          pat_valid_d = 1'b1;
        end
      end
      S_FLUSH: begin
        if (flush_q == FLUSH_LAST) state_d = S_DONE;
        else                       flush_d = flush_q + 3'd1;
      end
      default: state_d = S_IDLE;
    endcase

    // pass compares the signature including the final response folded this edge
    if (state_d == S_DONE && state_q != S_DONE) pass_d = (misr_d == golden_i);

    if (abort_i) begin
      state_d     = S_IDLE;
      lfsr_d      = lfsr_q;
      pattern_d   = pattern_q;
      pat_valid_d = 1'b0;
      cnt_d       = cnt_q;
      flush_d     = flush_q;
      dly_d       = '0;
      misr_d      = misr_q;
      pass_d      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      lfsr_q      <= '0;
      pattern_q   <= '0;
      pat_valid_q <= 1'b0;
      cnt_q       <= '0;
      flush_q     <= '0;
      dly_q       <= '0;
      misr_q      <= '0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      pattern_q   <= pattern_d;
      pat_valid_q <= pat_valid_d;
      cnt_q       <= cnt_d;
      flush_q     <= flush_d;
      dly_q       <= dly_d;
      misr_q      <= misr_d;
      pass_q      <= pass_d;
    end
  end

  assign pattern_o   = pattern_q;
  assign pat_valid_o = pat_valid_q;
  assign signature_o = misr_q;
  assign busy_o      = (state_q == S_RUN) || (state_q == S_FLUSH);
  assign done_o      = (state_q == S_DONE);
  assign pass_o      = pass_q;

endmodule

// File: doc/bist_engine.md
Name: bist_engine

Overview:
- Parameterised built-in self-test engine for one combinational or pipelined circuit-under-test (CUT).
- N_CH LFSR channels generate pattern words, which are driven to the CUT. CUT responses are compacted into a MISR signature, and the signature is compared against a golden value.
- Successor to the fixed six-channel, 256-pattern adder test harness: adds start/abort handshake, CUT latency handling, a zero-seed guard and a pass/fail compare.

Parameters:
- N_CH, 6, number of LFSR pattern channels
- LFSR_W, 7, width of each LFSR channel
- LFSR_TAPS, 7'h60, feedback mask; default polynomial x^7+x^6+1
- RESP_W, 17, CUT response width
- SIG_W, 10, MISR signature width
- MISR_TAPS, 10'h240, MISR feedback mask; default polynomial x^10+x^7+1
- PAT_CNT, 256, patterns per run; legal range 1..65535
- CUT_LAT, 1, CUT response latency in cycles; legal range 0..7

Ports:
- clk, input, 1, single clock, rising edge
- rst_n, input, 1, asynchronous active-low reset
- start, input, 1, run request; sampled in IDLE or DONE only
- abort, input, 1, synchronous abort; returns the engine to IDLE
- seeds, input, N_CH*LFSR_W, per-channel seeds; channel c occupies bits [c*LFSR_W +: LFSR_W]
- golden, input, SIG_W, expected signature
- pattern, output, N_CH*LFSR_W, registered pattern word to the CUT
- pat_valid, output, 1, pattern is a live test vector this cycle
- resp, input, RESP_W, CUT response
- signature, output, SIG_W, current MISR contents
- busy, output, 1, run in progress
- done, output, 1, run complete; held until the next start
- pass, output, 1, signature==golden; valid only while done=1

Behaviour:
- Reset values: all outputs 0, state IDLE, LFSRs 0, MISR 0, counters 0.
- States: IDLE, RUN, FLUSH, DONE.
- IDLE/DONE, start=1 at edge k:
  - Each LFSR loads its seed. A zero seed is replaced by all-ones.
  - MISR clears to 0, pattern counter clears to 0, done and pass clear.
  - State moves to RUN.
- RUN:
  - pattern = concatenated LFSR states, pat_valid=1, busy=1.
  - Every edge, each LFSR advances:
    - fb = XOR(state & LFSR_TAPS)
    - next = {state[LFSR_W-2:0], fb}
  - The first pattern equals the (guarded) seeds.
  - Patterns are presented in cycles k+1 .. k+PAT_CNT. After the PAT_CNT-th pattern the state moves to FLUSH.
  - If CUT_LAT=0, the state moves directly to DONE instead.
- Response capture:
  - A CUT_LAT-deep shift register delays pat_valid.
  - The MISR updates at the end of every cycle in which the delayed valid is 1. The response for the pattern of cycle t is sampled at the end of cycle t+CUT_LAT.
  - MISR update: fb = XOR(sig & MISR_TAPS); sig_next = {sig[SIG_W-2:0], fb} ^ fold(resp).
  - fold(resp) bit i = XOR of resp[j] over all j with j mod SIG_W == i.
- FLUSH: pat_valid=0, busy=1. Lasts exactly CUT_LAT cycles, then the state moves to DONE.
- DONE:
  - done=1, busy=0, pat_valid=0, pass=(signature==golden), registered on DONE entry.
  - done first asserts in cycle k+PAT_CNT+CUT_LAT+1.
  - signature holds its value.
- During RUN and FLUSH, pattern holds its last value whenever pat_valid=0.
- start during RUN/FLUSH: ignored.
- abort=1 in any state:
  - Next state IDLE; busy, done, pass, pat_valid cleared; delay line cleared.
  - signature keeps its partial value.
  - abort has priority over a simultaneous start.
- Counter wrap: the pattern counter is 16 bits and compares exactly against PAT_CNT-1, so it never wraps within a run.
- Asynchronous reset mid-run: immediate return to reset values; no partial DONE is reported.

Optional Feature:
- Macro: BIST_PHASE_SHIFT_EN.
- Defined: a phase shifter sits between the LFSRs and pattern. Channel c = lfsr[c] ^ rotl1(lfsr[(c+1) mod N_CH]). This decorrelates channels that share a seed.
- Undefined: channel c = lfsr[c] unmodified.
- The MISR, timing and handshake are identical in both builds. Golden values differ between builds.

Test Plan:
- LFSR sequence: seeds all 7'h01, PAT_CNT=3, CUT_LAT=0 -> every channel presents 01, 02, 04 in cycles k+1..k+3; done=1 at k+4.
- Zero-seed guard and period: seeds all 0, PAT_CNT=128 -> first pattern all 7'h7F; pattern 127 equals pattern 0 (127-cycle period).
- Zero response: resp tied to 0, PAT_CNT=256, CUT_LAT=1, golden=0 -> signature=0, done at k+258, pass=1. Repeat with golden=10'h001 -> pass=0.
- Latency alignment: CUT modelled as a 1-cycle register of the pattern low bits; compare signature against a bench model for CUT_LAT=1 and CUT_LAT=3 -> exact match, and FLUSH lasts 1 and 3 cycles respectively.
- Abort: assert abort at RUN cycle 100 together with start -> IDLE next cycle, busy=0, done=0. A new start then produces the same signature as an uninterrupted run.
- Start ignored: start pulsed during RUN -> counter and signature unaffected. Start in DONE -> done clears, new run begins.
